// File: rtl/req_encoder_rr.sv
// ---------------------------------------------------------------------------
// req_encoder_rr
//
// Registered request encoder. Request lines are ORed into a pending register
// every cycle, and one pending index at a time is offered to a single
// consumer over a valid/ready handshake. Each accepted index clears its
// pending bit on the same edge. Selection is either fixed priority (lowest
// index wins) or round-robin starting just after the last accepted index.
//
// Parameters:
//   N      number of request lines (>= 2, any value)
//   RR     0 = fixed priority (index 0 highest), 1 = round-robin
//   IDX_W  index width, derived from N
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request bits, ORed into pending every edge
//   clr        synchronous clear of pending, offer and overflow state
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a valid pending index (registered)
//   out_idx    offered index (registered)
//   pending    pending register, including the bit currently offered
//   ovf        sticky flag: a request arrived for a bit already pending
// ---------------------------------------------------------------------------
module req_encoder_rr #(
  parameter  int N     = 8,
  parameter  int RR    = 0,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [N-1:0]     pend_n;
  logic             ovf_n;
  logic [IDX_W-1:0] ptr, ptr_n;

  logic             transfer;
  logic [N-1:0]     take;
  logic [N-1:0]     pend_next;
  logic [N-1:0]     offer_mask;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] ptr_next;
  logic             dup;
  logic [IDX_W-1:0] sel;

  // First set bit of c at or above start, wrapping past N-1 back to 0.
  // With start = 0 this is plain lowest-index-first priority.
  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] c,
                                            input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] r;
    logic             found;
    int               j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && c[j]) begin
        r     = IDX_W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign out_valid = (state == OFFER);

  // Datapath shared by both states. The pointer used for selection is the
  // post-transfer value so a back-to-back reload already starts the search
  // just after the index being accepted; the wrap is at N, not 2^IDX_W.
  always_comb begin
    transfer   = out_valid && out_ready;
    take       = transfer ? (N'(1) << out_idx) : '0;
    pend_next  = (pending & ~take) | req;
    offer_mask = (out_valid && !out_ready) ? (N'(1) << out_idx) : '0;
    cand       = pend_next & ~offer_mask;
    if (transfer)
      ptr_next = (out_idx == IDX_W'(N - 1)) ? '0 : out_idx + IDX_W'(1);
    else
      ptr_next = ptr;
    // A request for a bit that stays pending is merged and flagged; a request
    // for the bit being taken this edge is a fresh request, not a duplicate.
    dup = |(req & pending & ~take);
    sel = (RR != 0) ? pick(cand, ptr_next) : pick(cand, '0);
  end

  // Next-state logic. A held offer is never preempted by newer requests;
  // clr wins over both new requests and a transfer on the same edge, and
  // leaves the round-robin pointer where it was.
  always_comb begin
    state_n = state;
    idx_n   = out_idx;
    pend_n  = pend_next;
    ovf_n   = ovf | dup;
    ptr_n   = ptr_next;
    if (clr) begin
      state_n = IDLE;
      pend_n  = '0;
      ovf_n   = 1'b0;
      ptr_n   = ptr;
    end else begin
      unique case (state)
        IDLE: begin
          if (|cand) begin
            idx_n   = sel;
            state_n = OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            if (|cand) idx_n = sel;
            else       state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register; reset drops any offer and discards all pending requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_idx <= '0;
      pending <= '0;
      ovf     <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      out_idx <= idx_n;
      pending <= pend_n;
      ovf     <= ovf_n;
      ptr     <= ptr_n;
    end
  end

endmodule

// File: tb/tb_req_encoder_rr.sv
// ---------------------------------------------------------------------------
// tb_req_encoder_rr
//
// Self-checking bench for req_encoder_rr. Three instances run side by side:
//   A: N=8, fixed priority   B: N=8, round-robin   C: N=6, round-robin
// A and B share one request bus, C has its own 6-bit bus; clr and out_ready
// are common. A behavioural model tracks each instance as an array of
// pending flags plus an offered index, and walks the request lines with
// modulo arithmetic to pick the next index.
// ---------------------------------------------------------------------------
module tb_req_encoder_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_ab;
  logic [5:0] req_c;
  logic       clr;
  logic       out_ready;

  logic       valid_a, valid_b, valid_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [7:0] pend_a, pend_b;
  logic [5:0] pend_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_cmp = 0;
  int n_bad = 0;

  req_encoder_rr #(.N(8), .RR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_ab), .clr(clr), .out_ready(out_ready),
    .out_valid(valid_a), .out_idx(idx_a), .pending(pend_a), .ovf(ovf_a));

  req_encoder_rr #(.N(8), .RR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_ab), .clr(clr), .out_ready(out_ready),
    .out_valid(valid_b), .out_idx(idx_b), .pending(pend_b), .ovf(ovf_b));

  req_encoder_rr #(.N(6), .RR(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .clr(clr), .out_ready(out_ready),
    .out_valid(valid_c), .out_idx(idx_c), .pending(pend_c), .ovf(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs gathered per instance so the checks can loop over them.
  logic       dv[3];
  logic [2:0] di[3];
  logic [7:0] dp[3];
  logic       dov[3];
  assign dv[0] = valid_a;  assign di[0] = idx_a;  assign dp[0] = pend_a;           assign dov[0] = ovf_a;
  assign dv[1] = valid_b;  assign di[1] = idx_b;  assign dp[1] = pend_b;           assign dov[1] = ovf_b;
  assign dv[2] = valid_c;  assign di[2] = idx_c;  assign dp[2] = {2'b00, pend_c};  assign dov[2] = ovf_c;

  // Behavioural model state, one slot per instance.
  int m_n[3]  = '{8, 8, 6};
  bit m_rr[3] = '{1'b0, 1'b1, 1'b1};
  bit m_pend[3][8];
  bit m_valid[3];
  int m_idx[3];
  int m_ptr[3];
  bit m_ovf[3];

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
      m_ptr[d]   = 0;
      m_ovf[d]   = 1'b0;
    end
  endfunction

  // One rising edge of instance d, in terms of the handshake rules: the
  // accepted line is serviced, new requests are merged, and a fresh index is
  // chosen whenever nothing is being held.
  function automatic void model_step(int d, logic [7:0] rq, logic c, logic rdy);
    int n = m_n[d];
    bit xfer;
    bit found;
    int start;
    int j;
    if (c) begin
      for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
      m_valid[d] = 1'b0;
      m_ovf[d]   = 1'b0;
      return;
    end
    xfer = m_valid[d] && rdy;
    for (int i = 0; i < n; i++)
      if (rq[i] && m_pend[d][i] && !(xfer && m_idx[d] == i)) m_ovf[d] = 1'b1;
    if (xfer) begin
      m_pend[d][m_idx[d]] = 1'b0;
      m_ptr[d] = (m_idx[d] + 1) % n;
    end
    for (int i = 0; i < n; i++)
      if (rq[i]) m_pend[d][i] = 1'b1;
    if (!m_valid[d] || xfer) begin
      found = 1'b0;
      start = m_rr[d] ? m_ptr[d] : 0;
      for (int k = 0; k < n; k++) begin
        j = (start + k) % n;
        if (!found && m_pend[d][j]) begin
          found    = 1'b1;
          m_idx[d] = j;
        end
      end
      m_valid[d] = found;
    end
  endfunction

  function automatic void check(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h, expected %0h", name, d, $time, act, exp);
    end
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model with
  // the same inputs, and return at the falling edge for sampling.
  task automatic applyStimulus(input logic [7:0] r8, input logic [5:0] r6,
                               input logic c, input logic rdy);
    req_ab    = r8;
    req_c     = r6;
    clr       = c;
    out_ready = rdy;
    @(posedge clk);
    model_step(0, r8, c, rdy);
    model_step(1, r8, c, rdy);
    model_step(2, {2'b00, r6}, c, rdy);
    @(negedge clk);
  endtask

  // Compare every instance against the model.
  task automatic checkOutput();
    logic [7:0] mp;
    for (int d = 0; d < 3; d++) begin
      mp = '0;
      for (int i = 0; i < 8; i++) mp[i] = m_pend[d][i];
      check("out_valid", d, 32'(dv[d]), 32'(m_valid[d]));
      if (m_valid[d]) check("out_idx", d, 32'(di[d]), 32'(m_idx[d]));
      check("idx_range", d, 32'(int'(di[d]) < m_n[d]), 32'd1);
      check("pending", d, 32'(dp[d]), 32'(mp));
      check("ovf", d, 32'(dov[d]), 32'(m_ovf[d]));
    end
  endtask

  typedef struct {
    logic [7:0] req;
    logic       clr;
    logic       ready;
    logic       exp_valid;
    int         exp_idx;
    logic [7:0] exp_pend;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[20];
  int   exp_rr8[4] = '{0, 7, 0, 7};
  int   exp_rr6[4] = '{0, 5, 0, 5};

  initial begin
    // Hand-derived vectors for the fixed-priority instance, run from a clean
    // state: ordered drain, backpressure, overflow, same-bit re-request,
    // no preemption, and clr beating a transfer.
    tbl[0]  = '{8'hA4, 1'b0, 1'b1, 1'b1, 2, 8'hA4, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 5, 8'hA0, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 7, 8'h80, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[5]  = '{8'h20, 1'b0, 1'b0, 1'b1, 5, 8'h20, 1'b0};
    tbl[6]  = '{8'h01, 1'b0, 1'b0, 1'b1, 5, 8'h21, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 8'h01, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[9]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3, 8'h08, 1'b0};
    tbl[10] = '{8'h08, 1'b0, 1'b0, 1'b1, 3, 8'h08, 1'b1};
    tbl[11] = '{8'h01, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[13] = '{8'h10, 1'b0, 1'b0, 1'b1, 4, 8'h10, 1'b0};
    tbl[14] = '{8'h10, 1'b0, 1'b1, 1'b1, 4, 8'h10, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    tbl[16] = '{8'h40, 1'b0, 1'b0, 1'b1, 6, 8'h40, 1'b0};
    tbl[17] = '{8'h02, 1'b0, 1'b0, 1'b1, 6, 8'h42, 1'b0};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h02, 1'b0};
    tbl[19] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0};

    // Reset held with every request line high: nothing may get through.
    rst_n     = 1'b0;
    req_ab    = 8'hFF;
    req_c     = 6'h3F;
    clr       = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", d, 32'(dv[d]), 32'd0);
      check("rst_idx", d, 32'(di[d]), 32'd0);
      check("rst_pend", d, 32'(dp[d]), 32'd0);
      check("rst_ovf", d, 32'(dov[d]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      applyStimulus(8'h00, 6'h00, 1'b0, 1'b1);
      checkOutput();
    end

    // Round-robin alternation from a fresh pointer, wrapping at N.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'h81, 6'h21, 1'b0, 1'b1);
      check("rr8_valid", 1, 32'(valid_b), 32'd1);
      check("rr8_idx", 1, 32'(idx_b), 32'(exp_rr8[k]));
      check("rr6_valid", 2, 32'(valid_c), 32'd1);
      check("rr6_idx", 2, 32'(idx_c), 32'(exp_rr6[k]));
      checkOutput();
    end

    // Asynchronous reset between edges during an offer.
    applyStimulus(8'h08, 6'h08, 1'b0, 1'b0);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      check("async_valid", d, 32'(dv[d]), 32'd0);
      check("async_pend", d, 32'(dp[d]), 32'd0);
      check("async_ovf", d, 32'(dov[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h04, 6'h04, 1'b0, 1'b0);
    check("post_rst_valid", 0, 32'(valid_a), 32'd1);
    check("post_rst_idx", 0, 32'(idx_a), 32'd2);
    checkOutput();
    applyStimulus(8'h00, 6'h00, 1'b1, 1'b0);
    checkOutput();

    // Table-driven vectors on the fixed-priority instance.
    for (int t = 0; t < 20; t++) begin
      applyStimulus(tbl[t].req, 6'h00, tbl[t].clr, tbl[t].ready);
      check("tbl_valid", t, 32'(valid_a), 32'(tbl[t].exp_valid));
      if (tbl[t].exp_valid) check("tbl_idx", t, 32'(idx_a), 32'(tbl[t].exp_idx));
      check("tbl_pend", t, 32'(pend_a), 32'(tbl[t].exp_pend));
      check("tbl_ovf", t, 32'(ovf_a), 32'(tbl[t].exp_ovf));
      checkOutput();
    end

    // Random traffic: sparse requests, bursty ready, rare clears.
    for (int t = 0; t < 500; t++) begin
      applyStimulus(8'($urandom) & 8'($urandom),
                    6'($urandom) & 6'($urandom),
                    ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 3) != 0));
      checkOutput();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/req_encoder_rr.md
# req_encoder_rr

Parametrised, registered request encoder: the sequential successor to the team's combinational one-hot-to-binary encoders. It captures N request lines into a pending register and emits one binary index per cycle over a valid/ready handshake. Each accepted index clears its pending bit. Selection is fixed-priority (lowest index wins) or round-robin, chosen by parameter. It sits between request-generating logic (interrupt lines, channel service flags) and a single consumer that services one index at a time.

## Interface
Parameters:
- N, 8: number of request lines; legal range N >= 2, any value, not restricted to powers of two.
- RR, 0: 0 = fixed priority with index 0 highest; 1 = round-robin.
- IDX_W, $clog2(N): index width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  request bits; each high bit is sampled every rising edge and ORed into pending.
- clr  input  1  synchronous clear of pending, offer and overflow state.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a valid pending index (registered).
- out_idx  output  IDX_W  offered index (registered).
- pending  output  N  pending register, including the bit currently offered.
- ovf  output  1  sticky overflow flag.

## Operation
- Handshake: a transfer occurs on any rising edge where out_valid && out_ready.
- take mask: one-hot(out_idx) on a transfer cycle, otherwise 0.
- Pending update: pend_next = (pending & ~take) | req. A req bit equal to the bit being taken re-sets that bit as a new request.
- Candidates: cand = pend_next & ~offer_mask. offer_mask is one-hot(out_idx) while out_valid && !out_ready, otherwise 0.
- State machine, two states:
  - IDLE (out_valid=0): if pend_next != 0, load out_idx = select(pend_next) and go to OFFER; otherwise stay in IDLE.
  - OFFER (out_valid=1):
    - If !out_ready: hold out_idx and out_valid unchanged. Newly arriving higher-priority requests do not preempt the offer.
    - If out_ready: if pend_next != 0, load the next index from pend_next and stay in OFFER (back-to-back, one index per cycle); otherwise go to IDLE.
- Selection:
  - RR=0: lowest set index.
  - RR=1: first set index at or above ptr, searching upward and wrapping past N-1 to 0. On each transfer, ptr <= (out_idx+1) mod N, wrapping at N, not at 2^IDX_W. ptr is not visible on ports.
- Overflow: ovf <= 1 when req[i]=1 while pending[i]=1 and bit i is not taken that edge. The duplicate request is merged, not queued. ovf stays set until clr or reset.
- clr has priority over req and over a transfer in the same cycle. After that edge: pending=0, out_valid=0, ovf=0, state IDLE. ptr is unchanged.
- An out_idx value >= N is never produced.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_idx=0, pending=0, ovf=0, ptr=0, state IDLE. The block leaves reset on the first rising edge after rst_n goes high.
- Latency: req high at edge k gives out_valid=1 and the index visible after edge k, one cycle.
- Throughput: one index per cycle while out_ready=1 and requests remain.
- The transferred bit is cleared from pending on the same edge as the transfer.
- Reset asserted mid-offer drops the offer immediately and discards all pending requests.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF -> all outputs 0. After release, with req=0, out_valid stays 0.
- Fixed priority, RR=0, N=8: req=8'b1010_0100 for one cycle, out_ready=1 -> out_idx 2, 5, 7 on three consecutive cycles, then out_valid=0 and pending=0.
- Backpressure: offer index 5 with out_ready=0, then pulse req bit 0 -> out_idx stays 5 and pending=8'b0010_0001. Raise out_ready -> 5 transfers, then 0 transfers.
- Round-robin, RR=1: hold req=8'b1000_0001, out_ready=1 -> out_idx sequence 0, 7, 0, 7. With N=6 and req=6'b100001 -> 0, 5, 0, 5, confirming the wrap at N.
- Overflow and clear: pulse req bit 3 twice with out_ready=0 -> ovf=1 and pending bit 3 set once. Assert clr together with req=8'h01 -> pending=0, out_valid=0, ovf=0.
- Async reset mid-stream: drop rst_n between clock edges during an OFFER -> outputs go to 0 without waiting for a clock edge. The next request after release is offered with one-cycle latency.
